// File: rtl/bf_addsub_0.sv
// bf_addsub_0 -- modular add/subtract butterfly back-end.
//
// Completes a Cooley-Tukey butterfly on the reduced product stream coming
// out of the multiply-reduce stage: sum = u + p, diff = u - p (mod q), with
// optional scaling of both results by 2^-1 mod q.
//   Kyber      (mode = 0): two independent 12-bit lanes, q = 3329
//   Dilithium  (mode = 1): one 23-bit lane,               q = 8380417
//
// The u operand arrives together with the multiplier operands, so it rides
// an alignment delay line of MUL_LAT stages to meet p. Two more registered
// stages follow (raw add/sub, then correction/halving), so out_valid is
// in_valid delayed by MUL_LAT + 2 cycles.
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous active-low reset
//   in_valid   u, mode, half valid this cycle
//   u[23:0]    Kyber {uH, uL}; Dilithium u[22:0] (bit 23 ignored)
//   mode       0 = Kyber, 1 = Dilithium
//   half       1 = scale both outputs by 2^-1 mod q
//   p[23:0]    reduced product, sampled MUL_LAT cycles after its in_valid
//   out_valid  sum/diff valid
//   sum[23:0]  (u + p) mod q (optionally halved); bit 23 = 0 in Dilithium
//   diff[23:0] (u - p) mod q (optionally halved); bit 23 = 0 in Dilithium

module bf_addsub_0 #(
   parameter int MUL_LAT = 3
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   input  logic [23:0] u,
   input  logic        mode,
   input  logic        half,
   input  logic [23:0] p,
   output logic        out_valid,
   output logic [23:0] sum,
   output logic [23:0] diff
);

   localparam logic [12:0] Q_KY      = 13'd3329;
   localparam logic [23:0] Q_DL      = 24'd8380417;
   // (x + q) >> 1 for odd x and odd q equals (x >> 1) + ((q - 1) / 2) + 1
   localparam logic [11:0] HALF_Q_KY = 12'd1665;
   localparam logic [22:0] HALF_Q_DL = 23'd4190209;

   // ------------------------------------------------------------------
   // Alignment delay line: valid shifts every cycle, payload only moves
   // along with a valid item so idle stages keep their old contents.
   // ------------------------------------------------------------------
   logic [MUL_LAT-1:0] dl_valid;
   logic [MUL_LAT-1:0] dl_mode;
   logic [MUL_LAT-1:0] dl_half;
   logic [23:0]        dl_u [MUL_LAT];

   always_ff @(posedge clk) begin
      if (!rst) begin
         dl_valid <= '0;
         dl_mode  <= '0;
         dl_half  <= '0;
         for (int k = 0; k < MUL_LAT; k++) begin
            dl_u[k] <= '0;
         end
      end else begin
         dl_valid[0] <= in_valid;
         if (in_valid) begin
            dl_u[0]    <= u;
            dl_mode[0] <= mode;
            dl_half[0] <= half;
         end
         for (int k = 1; k < MUL_LAT; k++) begin
            dl_valid[k] <= dl_valid[k-1];
            if (dl_valid[k-1]) begin
               dl_u[k]    <= dl_u[k-1];
               dl_mode[k] <= dl_mode[k-1];
               dl_half[k] <= dl_half[k-1];
            end
         end
      end
   end

   logic        al_valid;
   logic        al_mode;
   logic        al_half;
   logic [23:0] al_u;

   assign al_valid = dl_valid[MUL_LAT-1];
   assign al_mode  = dl_mode[MUL_LAT-1];
   assign al_half  = dl_half[MUL_LAT-1];
   assign al_u     = dl_u[MUL_LAT-1];

   // ------------------------------------------------------------------
   // Stage A: raw sums/differences. Both packings are computed every
   // cycle; stage B picks the one matching the item's mode. Kyber lanes
   // are zero-extended separately so nothing crosses bit 12.
   // ------------------------------------------------------------------
   logic [12:0] ks_h, ks_l, kd_h, kd_l;
   logic [23:0] ds, dd;

   assign ks_h = {1'b0, al_u[23:12]} + {1'b0, p[23:12]};
   assign ks_l = {1'b0, al_u[11:0]}  + {1'b0, p[11:0]};
   assign kd_h = {1'b0, al_u[23:12]} - {1'b0, p[23:12]};
   assign kd_l = {1'b0, al_u[11:0]}  - {1'b0, p[11:0]};
   assign ds   = {1'b0, al_u[22:0]}  + {1'b0, p[22:0]};
   assign dd   = {1'b0, al_u[22:0]}  - {1'b0, p[22:0]};

   logic        a_valid;
   logic        a_mode;
   logic        a_half;
   logic [12:0] a_ks_h, a_ks_l, a_kd_h, a_kd_l;
   logic [23:0] a_ds, a_dd;

   always_ff @(posedge clk) begin
      if (!rst) begin
         a_valid <= 1'b0;
         a_mode  <= 1'b0;
         a_half  <= 1'b0;
         a_ks_h  <= '0;
         a_ks_l  <= '0;
         a_kd_h  <= '0;
         a_kd_l  <= '0;
         a_ds    <= '0;
         a_dd    <= '0;
      end else begin
         a_valid <= al_valid;
         if (al_valid) begin
            a_mode <= al_mode;
            a_half <= al_half;
            a_ks_h <= ks_h;
            a_ks_l <= ks_l;
            a_kd_h <= kd_h;
            a_kd_l <= kd_l;
            a_ds   <= ds;
            a_dd   <= dd;
         end
      end
   end

   // ------------------------------------------------------------------
   // Stage B: one conditional correction, then optional halving.
   // Differences are two's complement in the raw width, so the top bit
   // is the "went negative" flag.
   // ------------------------------------------------------------------
   function automatic logic [11:0] ky_fix(input logic [12:0] x_raw,
                                          input logic        is_diff,
                                          input logic        h);
      logic [12:0] x;
      logic [11:0] res;
      if (is_diff) begin
         x = x_raw[12] ? x_raw + Q_KY : x_raw;
      end else begin
         x = (x_raw >= Q_KY) ? x_raw - Q_KY : x_raw;
      end
      if (h) begin
         res = x[12:1] + (x[0] ? HALF_Q_KY : 12'd0);
      end else begin
         res = x[11:0];
      end
      return res;
   endfunction

   function automatic logic [22:0] dl_fix(input logic [23:0] x_raw,
                                          input logic        is_diff,
                                          input logic        h);
      logic [23:0] x;
      logic [22:0] res;
      if (is_diff) begin
         x = x_raw[23] ? x_raw + Q_DL : x_raw;
      end else begin
         x = (x_raw >= Q_DL) ? x_raw - Q_DL : x_raw;
      end
      if (h) begin
         res = x[23:1] + (x[0] ? HALF_Q_DL : 23'd0);
      end else begin
         res = x[22:0];
      end
      return res;
   endfunction

   logic [23:0] b_sum, b_diff;

   always_comb begin
      b_sum  = '0;
      b_diff = '0;
      if (a_mode) begin
         b_sum  = {1'b0, dl_fix(a_ds, 1'b0, a_half)};
         b_diff = {1'b0, dl_fix(a_dd, 1'b1, a_half)};
      end else begin
         b_sum  = {ky_fix(a_ks_h, 1'b0, a_half), ky_fix(a_ks_l, 1'b0, a_half)};
         b_diff = {ky_fix(a_kd_h, 1'b1, a_half), ky_fix(a_kd_l, 1'b1, a_half)};
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         out_valid <= 1'b0;
         sum       <= '0;
         diff      <= '0;
      end else begin
         out_valid <= a_valid;
         if (a_valid) begin
            sum  <= b_sum;
            diff <= b_diff;
         end
      end
   end

endmodule

// File: tb/tb_bf_addsub_0.sv
// Testbench for bf_addsub_0: directed butterfly cases, streaming with
// mixed modes and bubbles, mid-stream reset and a randomized run, all
// checked against a modular-arithmetic reference model.

module tb_bf_addsub_0;

   localparam int MUL_LAT = 3;
   localparam longint QK  = 3329;
   localparam longint QD  = 8380417;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        in_valid = 1'b0;
   logic [23:0] u = '0;
   logic        mode = 1'b0;
   logic        half = 1'b0;
   logic [23:0] p;
   logic        out_valid;
   logic [23:0] sum;
   logic [23:0] diff;

   logic [23:0] p_item = '0;
   logic [23:0] mpipe [MUL_LAT];

   int n_checks = 0;
   int n_errors = 0;
   int cyc = 0;
   bit iv_hist [8192];
   logic [47:0] exp_q [$];
   logic [23:0] hold_s = '0;
   logic [23:0] hold_d = '0;

   bf_addsub_0 #(.MUL_LAT(MUL_LAT)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .u         (u),
      .mode      (mode),
      .half      (half),
      .p         (p),
      .out_valid (out_valid),
      .sum       (sum),
      .diff      (diff)
   );

   always #5 clk = ~clk;

   // Stand-in for the multiply-reduce stage: returns the product MUL_LAT
   // cycles after the operands were accepted.
   always @(posedge clk) begin
      mpipe[0] <= in_valid ? p_item : 24'd0;
      for (int k = 1; k < MUL_LAT; k++) begin
         mpipe[k] <= mpipe[k-1];
      end
   end
   assign p = mpipe[MUL_LAT-1];

   task automatic chk(input string tag, input logic [23:0] got, input logic [23:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s at step %0d: got %0d expected %0d", tag, cyc, got, exp);
      end
   endtask

   function automatic longint lane_ref(longint a, longint b, longint q, bit sub, bit h);
      longint x;
      if (sub) x = ((a - b) % q + q) % q;
      else     x = (a + b) % q;
      if (h)   x = (x * ((q + 1) / 2)) % q;
      return x;
   endfunction

   function automatic logic [47:0] model(bit m, bit h, logic [23:0] uu, logic [23:0] pp);
      longint sh, sl, dh, dl;
      logic [23:0] s, d;
      if (m) begin
         sl = lane_ref(longint'(uu[22:0]), longint'(pp[22:0]), QD, 1'b0, h);
         dl = lane_ref(longint'(uu[22:0]), longint'(pp[22:0]), QD, 1'b1, h);
         s = 24'(sl);
         d = 24'(dl);
      end else begin
         sh = lane_ref(longint'(uu[23:12]), longint'(pp[23:12]), QK, 1'b0, h);
         sl = lane_ref(longint'(uu[11:0]),  longint'(pp[11:0]),  QK, 1'b0, h);
         dh = lane_ref(longint'(uu[23:12]), longint'(pp[23:12]), QK, 1'b1, h);
         dl = lane_ref(longint'(uu[11:0]),  longint'(pp[11:0]),  QK, 1'b1, h);
         s = {12'(sh), 12'(sl)};
         d = {12'(dh), 12'(dl)};
      end
      return {s, d};
   endfunction

   // Compare outputs of the cycle just ended: out_valid must be in_valid
   // delayed by MUL_LAT+2; valid results pop the expectation queue, idle
   // cycles must hold the previous results.
   task automatic monitor();
      int  src;
      bit  ev;
      logic [47:0] e;
      src = cyc - MUL_LAT - 2;
      ev  = (src >= 0) ? iv_hist[src] : 1'b0;
      chk("out_valid", {23'd0, out_valid}, {23'd0, ev});
      if (ev && exp_q.size() > 0) begin
         e = exp_q.pop_front();
         chk("sum", sum, e[47:24]);
         chk("diff", diff, e[23:0]);
         hold_s = e[47:24];
         hold_d = e[23:0];
      end else if (!ev) begin
         chk("sum_hold", sum, hold_s);
         chk("diff_hold", diff, hold_d);
      end
   endtask

   task automatic step(bit v, bit r, bit m, bit h, logic [23:0] uu, logic [23:0] pp,
                       logic [23:0] es, logic [23:0] ed);
      @(negedge clk);
      monitor();
      rst      = r;
      in_valid = v;
      mode     = m;
      half     = h;
      u        = uu;
      p_item   = pp;
      if (!r) begin
         exp_q.delete();
         for (int i = 0; i <= cyc; i++) iv_hist[i] = 1'b0;
         hold_s = '0;
         hold_d = '0;
      end
      iv_hist[cyc] = v && r;
      if (v && r) exp_q.push_back({es, ed});
      cyc++;
   endtask

   task automatic idle(int n);
      for (int i = 0; i < n; i++) step(1'b0, 1'b1, 1'b0, 1'b0, 24'd0, 24'd0, 24'd0, 24'd0);
   endtask

   task automatic do_reset();
      step(1'b0, 1'b0, 1'b0, 1'b0, 24'd0, 24'd0, 24'd0, 24'd0);
   endtask

   task automatic issue_exp(bit m, bit h, logic [23:0] uu, logic [23:0] pp,
                            logic [23:0] es, logic [23:0] ed);
      step(1'b1, 1'b1, m, h, uu, pp, es, ed);
   endtask

   task automatic issue(bit m, bit h, logic [23:0] uu, logic [23:0] pp);
      logic [47:0] e;
      e = model(m, h, uu, pp);
      step(1'b1, 1'b1, m, h, uu, pp, e[47:24], e[23:0]);
   endtask

   function automatic logic [23:0] rand_op(bit m);
      logic [23:0] x;
      if (m) x = {1'($urandom_range(0, 1)), 23'($urandom_range(0, 32'(QD - 1)))};
      else   x = {12'($urandom_range(0, 32'(QK - 1))), 12'($urandom_range(0, 32'(QK - 1)))};
      return x;
   endfunction

   task automatic issue_rand(bit m, bit h);
      issue(m, h, rand_op(m), rand_op(m));
   endtask

   initial begin
      do_reset();
      do_reset();
      idle(2);

      // Kyber basic
      issue_exp(1'b0, 1'b0, {12'd100, 12'd3000}, {12'd3300, 12'd500},
                {12'd71, 12'd171}, {12'd129, 12'd2500});
      idle(MUL_LAT + 3);
      // Dilithium wrap
      issue_exp(1'b1, 1'b0, 24'd8380000, 24'd1000, 24'd583, 24'd8379000);
      issue_exp(1'b1, 1'b0, 24'd5, 24'd10, 24'd15, 24'd8380412);
      idle(MUL_LAT + 3);
      // Halving
      issue_exp(1'b0, 1'b1, {12'd1, 12'd0}, {12'd2, 12'd0},
                {12'd1666, 12'd0}, {12'd1664, 12'd0});
      issue_exp(1'b1, 1'b1, 24'd1, 24'd0, 24'd4190209, 24'd4190209);
      idle(MUL_LAT + 3);
      // Boundaries
      issue_exp(1'b0, 1'b0, {12'd3328, 12'd3328}, {12'd3328, 12'd3328},
                {12'd3327, 12'd3327}, 24'd0);
      issue_exp(1'b1, 1'b0, 24'd0, 24'd0, 24'd0, 24'd0);
      issue_exp(1'b1, 1'b0, 24'd0, 24'd8380416, 24'd8380416, 24'd1);
      idle(MUL_LAT + 3);

      // Streaming: alternating mode with bubbles at items 5 and 11
      for (int i = 0; i < 16; i++) begin
         if (i == 5 || i == 11) idle(1);
         else issue_rand(1'(i % 2), 1'($urandom_range(0, 1)));
      end
      idle(MUL_LAT + 3);

      // Reset with three items in flight; none may emerge afterwards
      for (int i = 0; i < 3; i++) issue_rand(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      do_reset();
      idle(MUL_LAT + 4);
      issue_rand(1'b0, 1'b0);
      idle(MUL_LAT + 4);

      // Randomized traffic
      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(0, 3) == 0) idle(1);
         else issue_rand(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      end
      idle(MUL_LAT + 4);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
